// File: rtl/settings_pkg.sv
// Shared settings for the multi-channel convolution core.
// Holds the datapath widths, derived result/channel widths, the
// sample/coefficient/result types and the coefficient-bank FSM states.
package settings_pkg;

  localparam int unsigned DATA_SIZE    = 16;
  localparam int unsigned COEFF_SIZE   = 16;
  localparam int unsigned WINDOW_SIZE  = 8;
  localparam int unsigned NUM_CHANNELS = 4;

  localparam int unsigned TAP_W      = $clog2(WINDOW_SIZE);
  localparam int unsigned TREE_DEPTH = TAP_W;
  localparam int unsigned PROD_SIZE  = DATA_SIZE + COEFF_SIZE;
  localparam int unsigned FULL_SIZE  = PROD_SIZE + TAP_W;
  localparam int unsigned CH_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef logic signed [DATA_SIZE-1:0]  sample_t;
  typedef logic signed [COEFF_SIZE-1:0] coeff_t;
  typedef logic signed [PROD_SIZE-1:0]  prod_t;
  typedef logic signed [FULL_SIZE-1:0]  result_t;
  typedef logic [CH_W-1:0]              chan_t;

  typedef coeff_t  coeff_bank_t [WINDOW_SIZE];
  typedef sample_t tap_line_t   [WINDOW_SIZE];

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } conv_state_t;

  // Full-precision signed product of one tap.
  function automatic prod_t mul_tap(input sample_t x, input coeff_t c);
    return PROD_SIZE'(x) * PROD_SIZE'(c);
  endfunction

endpackage

// File: rtl/convol_adder_tree.sv
// Registered binary adder tree with stall enable.
// Each level sums adjacent pairs and grows by one sign-extended bit, so the
// final sum can never overflow. A valid bit and a tag travel alongside.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   en              advance all levels (low = hold)
//   in_valid/in_tag sideband entering with in_data
//   in_data         LEAVES signed operands of IN_W bits
//   out_valid/out_tag/out_data  final level registers
//   any_valid       some level holds a valid token
module convol_adder_tree #(
  parameter int unsigned IN_W   = 32,
  parameter int unsigned LEAVES = 8,
  parameter int unsigned TAG_W  = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   en,
  input  logic                                   in_valid,
  input  logic [TAG_W-1:0]                       in_tag,
  input  logic signed [IN_W-1:0]                 in_data [LEAVES],
  output logic                                   out_valid,
  output logic [TAG_W-1:0]                       out_tag,
  output logic signed [IN_W+$clog2(LEAVES)-1:0]  out_data,
  output logic                                   any_valid
);

  localparam int unsigned DEPTH = $clog2(LEAVES);

  logic [DEPTH-1:0] lvl_valid;

  genvar l;
  for (l = 0; l < DEPTH; l++) begin : g_lvl
    localparam int unsigned NO = LEAVES >> (l + 1);
    localparam int unsigned IW = IN_W + l;
    localparam int unsigned OW = IW + 1;

    logic signed [IW-1:0] a [2*NO];
    logic                 a_valid;
    logic [TAG_W-1:0]     a_tag;
    logic signed [OW-1:0] sum [NO];
    logic                 vld;
    logic [TAG_W-1:0]     tag;

    // Level input: tree leaves or the previous level's registers.
    if (l == 0) begin : g_src
      assign a       = in_data;
      assign a_valid = in_valid;
      assign a_tag   = in_tag;
    end else begin : g_src
      assign a       = g_lvl[l-1].sum;
      assign a_valid = g_lvl[l-1].vld;
      assign a_tag   = g_lvl[l-1].tag;
    end

    // Pairwise sign-extended sums.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld <= 1'b0;
        tag <= '0;
        for (int unsigned i = 0; i < NO; i++) sum[i] <= '0;
      end else if (en) begin
        vld <= a_valid;
        tag <= a_tag;
        for (int unsigned i = 0; i < NO; i++) sum[i] <= OW'(a[2*i]) + OW'(a[2*i+1]);
      end
    end

    assign lvl_valid[l] = vld;
  end

  assign out_data  = g_lvl[DEPTH-1].sum[0];
  assign out_valid = g_lvl[DEPTH-1].vld;
  assign out_tag   = g_lvl[DEPTH-1].tag;
  assign any_valid = |lvl_valid;

endmodule

// File: rtl/convol_mc_core.sv
// Multi-channel windowed convolution engine.
// NUM_CHANNELS interleaved streams share one MAC pipeline: tap build/delay
// line update -> per-tap products -> registered adder tree. Coefficients are
// written into a shadow bank and swapped into the active bank only after the
// pipeline has drained, so every result uses exactly one bank.
// Optional build macro CONVOL_CHAN_CLEAR_EN adds chan_clear/chan_clear_id to
// zero one channel's history at run time.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   input_data/input_channel/enable/ready  sample input handshake
//   coeff_data/coeff_addr/coeff_wr         shadow bank write
//   coeff_commit            request shadow -> active swap
//   busy                    draining or swapping
//   output_data/output_channel/output_data_valid/output_ready  result handshake
//   chan_clear/chan_clear_id (CONVOL_CHAN_CLEAR_EN only) history clear
module convol_mc_core
  import settings_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [DATA_SIZE-1:0] input_data,
  input  logic [CH_W-1:0]             input_channel,
  input  logic                        enable,
  output logic                        ready,
  input  logic signed [COEFF_SIZE-1:0] coeff_data,
  input  logic [TAP_W-1:0]            coeff_addr,
  input  logic                        coeff_wr,
  input  logic                        coeff_commit,
  output logic                        busy,
  output logic signed [FULL_SIZE-1:0] output_data,
  output logic [CH_W-1:0]             output_channel,
  output logic                        output_data_valid,
  input  logic                        output_ready
`ifdef CONVOL_CHAN_CLEAR_EN
  ,
  input  logic                        chan_clear,
  input  logic [CH_W-1:0]             chan_clear_id
`endif
);

  conv_state_t state_q, state_d;

  coeff_bank_t active_q;
  coeff_bank_t shadow_q;

  sample_t     hist_q [NUM_CHANNELS][WINDOW_SIZE];

  logic        s1_valid_q;
  chan_t       s1_ch_q;
  tap_line_t   s1_taps_q;

  logic        s2_valid_q;
  chan_t       s2_ch_q;
  prod_t       s2_prod_q [WINDOW_SIZE];

  tap_line_t   hist_sel;
  tap_line_t   taps_new;

  logic        stall;
  logic        accept;
  logic        ch_ok;
  logic        tree_en;
  logic        tree_busy;
  logic        pipe_empty;

  // A held result freezes the whole pipeline, delay lines included.
  assign stall   = output_data_valid && !output_ready;
  assign ready   = (state_q == RUN) && !stall;
  assign accept  = enable && ready;
  assign tree_en = !stall;

  // Out-of-range channels only exist when NUM_CHANNELS is not a power of two.
  if ((1 << CH_W) > NUM_CHANNELS) begin : g_ch_chk
    assign ch_ok = (input_channel < CH_W'(NUM_CHANNELS));
  end else begin : g_ch_all
    assign ch_ok = 1'b1;
  end

`ifdef CONVOL_CHAN_CLEAR_EN
  logic clr_en;
  assign clr_en = chan_clear && !stall;
`endif

  // Updated tap vector for the addressed channel: newest sample + shifted history.
  always_comb begin
    hist_sel = '{default: '0};
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (CH_W'(c) == input_channel) hist_sel = hist_q[c];
    end
`ifdef CONVOL_CHAN_CLEAR_EN
    if (clr_en && (chan_clear_id == input_channel)) hist_sel = '{default: '0};
`endif
    taps_new[0] = input_data;
    for (int unsigned k = 1; k < WINDOW_SIZE; k++) taps_new[k] = hist_sel[k-1];
  end

  // Delay lines and stage 1 (tap vector + channel).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++)
        for (int unsigned k = 0; k < WINDOW_SIZE; k++) hist_q[c][k] <= '0;
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      for (int unsigned k = 0; k < WINDOW_SIZE; k++) s1_taps_q[k] <= '0;
    end else if (!stall) begin
`ifdef CONVOL_CHAN_CLEAR_EN
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        if (clr_en && (CH_W'(c) == chan_clear_id))
          for (int unsigned k = 0; k < WINDOW_SIZE; k++) hist_q[c][k] <= '0;
      end
`endif
      // Accepted sample overrides a same-cycle clear of its own channel.
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        if (accept && ch_ok && (CH_W'(c) == input_channel)) hist_q[c] <= taps_new;
      end
      s1_valid_q <= accept && ch_ok;
      s1_ch_q    <= input_channel;
      s1_taps_q  <= taps_new;
    end
  end

  // Stage 2: per-tap products against the active bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_ch_q    <= '0;
      for (int unsigned k = 0; k < WINDOW_SIZE; k++) s2_prod_q[k] <= '0;
    end else if (!stall) begin
      s2_valid_q <= s1_valid_q;
      s2_ch_q    <= s1_ch_q;
      for (int unsigned k = 0; k < WINDOW_SIZE; k++)
        s2_prod_q[k] <= mul_tap(s1_taps_q[k], active_q[k]);
    end
  end

  // Coefficient banks: shadow always writable, active copied only in SWAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < WINDOW_SIZE; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      if (coeff_wr) shadow_q[coeff_addr] <= coeff_data;
      if (state_q == SWAP) active_q <= shadow_q;
    end
  end

  convol_adder_tree #(
    .IN_W   (PROD_SIZE),
    .LEAVES (WINDOW_SIZE),
    .TAG_W  (CH_W)
  ) u_tree (
    .clk       (clk),
    .reset     (reset),
    .en        (tree_en),
    .in_valid  (s2_valid_q),
    .in_tag    (s2_ch_q),
    .in_data   (s2_prod_q),
    .out_valid (output_data_valid),
    .out_tag   (output_channel),
    .out_data  (output_data),
    .any_valid (tree_busy)
  );

  assign pipe_empty = !s1_valid_q && !s2_valid_q && !tree_busy;

  // Bank-swap FSM state register; busy is registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != RUN);
    end
  end

  // Bank-swap FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (coeff_commit) state_d = DRAIN;
      DRAIN:   if (pipe_empty)   state_d = SWAP;
      SWAP:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_convol_mc_core.sv
// Directed self-checking bench for convol_mc_core (default build).
module tb_convol_mc_core;

  logic               clk;
  logic               reset;
  logic signed [15:0] input_data;
  logic [1:0]         input_channel;
  logic               enable;
  logic               ready;
  logic signed [15:0] coeff_data;
  logic [2:0]         coeff_addr;
  logic               coeff_wr;
  logic               coeff_commit;
  logic               busy;
  logic signed [34:0] output_data;
  logic [1:0]         output_channel;
  logic               output_data_valid;
  logic               output_ready;
`ifdef CONVOL_CHAN_CLEAR_EN
  logic               chan_clear;
  logic [1:0]         chan_clear_id;
`endif

  int checks = 0;
  int errors = 0;

  logic signed [34:0] got_data [$];
  logic [1:0]         got_ch   [$];

  convol_mc_core dut (
    .clk               (clk),
    .reset             (reset),
    .input_data        (input_data),
    .input_channel     (input_channel),
    .enable            (enable),
    .ready             (ready),
    .coeff_data        (coeff_data),
    .coeff_addr        (coeff_addr),
    .coeff_wr          (coeff_wr),
    .coeff_commit      (coeff_commit),
    .busy              (busy),
    .output_data       (output_data),
    .output_channel    (output_channel),
    .output_data_valid (output_data_valid),
    .output_ready      (output_ready)
`ifdef CONVOL_CHAN_CLEAR_EN
    ,
    .chan_clear        (chan_clear),
    .chan_clear_id     (chan_clear_id)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every completed output transfer (sampled mid-cycle).
  always @(negedge clk) begin
    if (!reset && output_data_valid && output_ready) begin
      got_data.push_back(output_data);
      got_ch.push_back(output_channel);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_log();
    got_data.delete();
    got_ch.delete();
  endtask

  task automatic send(input logic [1:0] ch, input int d);
    int guard;
    guard = 0;
    input_channel = ch;
    input_data    = 16'(d);
    enable        = 1'b1;
    while (!ready && guard < 200) begin
      step();
      guard++;
    end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: ready stayed %0b, required 1", ready);
    end
    step();
    enable = 1'b0;
  endtask

  task automatic write_bank(input int v [8]);
    for (int k = 0; k < 8; k++) begin
      coeff_wr   = 1'b1;
      coeff_addr = 3'(k);
      coeff_data = 16'(v[k]);
      step();
    end
    coeff_wr = 1'b0;
  endtask

  task automatic commit_wait();
    int guard;
    guard = 0;
    coeff_commit = 1'b1;
    step();
    coeff_commit = 1'b0;
    while (busy && guard < 100) begin
      step();
      guard++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL commit_timeout: busy %0b, required 0", busy);
    end
  endtask

  task automatic wait_outputs(input int n);
    int guard;
    guard = 0;
    while (got_data.size() < n && guard < 300) begin
      step();
      guard++;
    end
    if (got_data.size() < n) begin
      checks++; errors++;
      $display("FAIL output_timeout: got %0d results, required %0d", got_data.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    checks++; if (output_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b required 0", output_data_valid); end
    checks++; if (output_data !== 35'sd0) begin errors++; $display("FAIL reset_data: got %0d required 0", output_data); end
    checks++; if (output_channel !== 2'd0) begin errors++; $display("FAIL reset_channel: got %0d required 0", output_channel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b required 1", ready); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_impulse();
    clear_log();
    write_bank('{1, 1, 1, 1, 1, 1, 1, 1});
    coeff_commit = 1'b1;
    step();
    coeff_commit = 1'b0;
    checks++; if (busy !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL drain_state: busy %0b ready %0b required 1 0", busy, ready); end
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL swap_busy: got %0b required 1", busy); end
    step();
    checks++; if (busy !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL run_after_swap: busy %0b ready %0b required 0 1", busy, ready); end

    send(2'd0, 100);
    idle(3);
    checks++; if (output_data_valid !== 1'b0) begin errors++; $display("FAIL latency_early: valid %0b required 0", output_data_valid); end
    step();
    checks++; if (output_data_valid !== 1'b1 || output_data !== 35'sd100) begin errors++; $display("FAIL latency_first: valid %0b data %0d required 1 100", output_data_valid, output_data); end

    for (int i = 0; i < 8; i++) send(2'd0, 0);
    wait_outputs(9);
    for (int i = 0; i < 9; i++) begin
      longint e;
      e = (i < 8) ? 100 : 0;
      checks++;
      if (got_data[i] !== 35'(e) || got_ch[i] !== 2'd0) begin
        errors++;
        $display("FAIL impulse[%0d]: got %0d ch %0d required %0d ch 0", i, got_data[i], got_ch[i], e);
      end
    end
  endtask

  task automatic test_interleave();
    write_bank('{1, 2, 3, 4, 5, 6, 7, 8});
    commit_wait();
    clear_log();
    for (int r = 0; r < 8; r++) begin
      send(2'd0, 1);
      send(2'd1, -1);
    end
    send(2'd2, 5);
    send(2'd3, 7);
    wait_outputs(18);
    for (int r = 0; r < 8; r++) begin
      longint e;
      e = longint'((r + 1) * (r + 2) / 2);
      checks++;
      if (got_data[2*r] !== 35'(e) || got_ch[2*r] !== 2'd0) begin
        errors++; $display("FAIL interleave_ch0[%0d]: got %0d ch %0d required %0d ch 0", r, got_data[2*r], got_ch[2*r], e);
      end
      checks++;
      if (got_data[2*r+1] !== 35'(-e) || got_ch[2*r+1] !== 2'd1) begin
        errors++; $display("FAIL interleave_ch1[%0d]: got %0d ch %0d required %0d ch 1", r, got_data[2*r+1], got_ch[2*r+1], -e);
      end
    end
    checks++; if (got_data[16] !== 35'sd5 || got_ch[16] !== 2'd2) begin errors++; $display("FAIL ch2_first: got %0d ch %0d required 5 ch 2", got_data[16], got_ch[16]); end
    checks++; if (got_data[17] !== 35'sd7 || got_ch[17] !== 2'd3) begin errors++; $display("FAIL ch3_first: got %0d ch %0d required 7 ch 3", got_data[17], got_ch[17]); end
  endtask

  task automatic test_stall();
    int expv [3];
    expv = '{37, 40, 46};
    clear_log();
    send(2'd0, 2);
    send(2'd0, 3);
    send(2'd0, 4);
    output_ready = 1'b0;
    idle(2);
    checks++; if (output_data_valid !== 1'b1 || output_data !== 35'sd37) begin errors++; $display("FAIL stall_head: valid %0b data %0d required 1 37", output_data_valid, output_data); end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (ready !== 1'b0 || output_data !== 35'sd37 || output_data_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d]: ready %0b valid %0b data %0d required 0 1 37", i, ready, output_data_valid, output_data);
      end
    end
    checks++; if (got_data.size() != 0) begin errors++; $display("FAIL stall_no_transfer: got %0d transfers required 0", got_data.size()); end
    output_ready = 1'b1;
    wait_outputs(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_data[i] !== 35'(expv[i]) || got_ch[i] !== 2'd0) begin
        errors++; $display("FAIL stall_order[%0d]: got %0d ch %0d required %0d ch 0", i, got_data[i], got_ch[i], expv[i]);
      end
    end
  endtask

  task automatic test_commit();
    clear_log();
    write_bank('{2, 2, 2, 2, 2, 2, 2, 2});
    coeff_commit = 1'b1;
    send(2'd0, 1);
    coeff_commit = 1'b0;
    checks++; if (ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL commit_drain: ready %0b busy %0b required 0 1", ready, busy); end
    idle(5);
    checks++; if (ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL drain_hold: ready %0b busy %0b required 0 1", ready, busy); end
    checks++; if (got_data.size() != 1 || got_data[0] !== 35'sd52) begin errors++; $display("FAIL pre_commit_result: count %0d data %0d required 1 52", got_data.size(), got_data[0]); end
    step();
    checks++; if (busy !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL swap_cycle: busy %0b ready %0b required 1 0", busy, ready); end
    coeff_wr   = 1'b1;
    coeff_addr = 3'd0;
    coeff_data = 16'sd9;
    step();
    coeff_wr = 1'b0;
    checks++; if (busy !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL post_swap: busy %0b ready %0b required 0 1", busy, ready); end
    send(2'd0, 1);
    wait_outputs(2);
    checks++; if (got_data[1] !== 35'sd28 || got_ch[1] !== 2'd0) begin errors++; $display("FAIL post_swap_result: got %0d ch %0d required 28 ch 0", got_data[1], got_ch[1]); end
  endtask

  task automatic test_extremes();
    write_bank('{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768});
    commit_wait();
    clear_log();
    for (int n = 0; n < 8; n++) send(2'd3, -32768);
    wait_outputs(8);
    for (int n = 0; n < 8; n++) begin
      longint e;
      e = (longint'(n + 1) <<< 30);
      if (n < 7) e = e - 64'sd229376;
      checks++;
      if (got_data[n] !== 35'(e) || got_ch[n] !== 2'd3) begin
        errors++; $display("FAIL extreme[%0d]: got %0d ch %0d required %0d ch 3", n, got_data[n], got_ch[n], e);
      end
    end
    checks++; if (got_data[7] !== 35'sd8589934592) begin errors++; $display("FAIL extreme_max: got %0d required 8589934592", got_data[7]); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    send(2'd0, 10);
    send(2'd0, 20);
    send(2'd0, 30);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (output_data_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %0b required 0", output_data_valid); end
    checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: ready %0b busy %0b required 1 0", ready, busy); end
    idle(6);
    checks++; if (got_data.size() != 0) begin errors++; $display("FAIL midreset_flush: got %0d results required 0", got_data.size()); end
    send(2'd1, 100);
    wait_outputs(1);
    checks++; if (got_data[0] !== 35'sd0 || got_ch[0] !== 2'd1) begin errors++; $display("FAIL active_zeroed: got %0d ch %0d required 0 ch 1", got_data[0], got_ch[0]); end
    coeff_wr   = 1'b1;
    coeff_addr = 3'd0;
    coeff_data = 16'sd1;
    step();
    coeff_wr = 1'b0;
    commit_wait();
    send(2'd1, 3);
    wait_outputs(2);
    checks++; if (got_data[1] !== 35'sd3) begin errors++; $display("FAIL shadow_zeroed: got %0d required 3", got_data[1]); end
    write_bank('{1, 1, 1, 1, 1, 1, 1, 1});
    commit_wait();
    send(2'd2, 1);
    wait_outputs(3);
    checks++; if (got_data[2] !== 35'sd1 || got_ch[2] !== 2'd2) begin errors++; $display("FAIL history_zeroed: got %0d ch %0d required 1 ch 2", got_data[2], got_ch[2]); end
  endtask

  initial begin
    reset         = 1'b1;
    input_data    = '0;
    input_channel = '0;
    enable        = 1'b0;
    coeff_data    = '0;
    coeff_addr    = '0;
    coeff_wr      = 1'b0;
    coeff_commit  = 1'b0;
    output_ready  = 1'b1;
`ifdef CONVOL_CHAN_CLEAR_EN
    chan_clear    = 1'b0;
    chan_clear_id = '0;
`endif
    #1;
    test_reset();
    test_impulse();
    test_interleave();
    test_stall();
    test_commit();
    test_extremes();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
